// File: rtl/gate_pkg.sv
// Shared definitions for the vector gate pipeline: op encoding and flag payload.
package gate_pkg;

    localparam int unsigned OP_W = 3;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_AND    = 3'd0;
    localparam op_t OP_NAND   = 3'd1;
    localparam op_t OP_OR     = 3'd2;
    localparam op_t OP_NOR    = 3'd3;
    localparam op_t OP_XOR    = 3'd4;
    localparam op_t OP_XNOR   = 3'd5;
    localparam op_t OP_PASS_A = 3'd6;
    localparam op_t OP_NOT_A  = 3'd7;

    // Result flags travelling with out_z in the output stage.
    typedef struct packed {
        logic zero;
        logic ones;
        logic par;
    } flags_t;

endpackage

// File: rtl/gate_vec.sv
// Combinational bitwise gate evaluation.
//   a, b : WIDTH-bit operands (b unused by PASS_A / NOT_A)
//   op   : gate select (gate_pkg::op_t)
//   z    : WIDTH-bit result
module gate_vec
    import gate_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    output logic [WIDTH-1:0] z
);

    always_comb begin
        z = '0;
        case (op)
            OP_AND:    z = a & b;
            OP_NAND:   z = ~(a & b);
            OP_OR:     z = a | b;
            OP_NOR:    z = ~(a | b);
            OP_XOR:    z = a ^ b;
            OP_XNOR:   z = ~(a ^ b);
            OP_PASS_A: z = a;
            OP_NOT_A:  z = ~a;
            default:   z = '0;
        endcase
    end

endmodule

// File: rtl/gate_vec_pipe.sv
// Two-stage valid/ready pipeline applying a bitwise gate op per transaction,
// with an optional feedback accumulator and registered result flags.
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready        : operand handshake (in_ready combinational from out_ready)
//   in_a, in_b, in_op        : operands and op select
//   in_acc                   : use accumulator as A and write the result back
//   acc_clr                  : clear accumulator (applies before an in_acc op in the same cycle)
//   out_valid/out_ready      : result handshake
//   out_z, out_zero/ones/par : registered result and its flags
//   acc_q                    : accumulator value
module gate_vec_pipe
    import gate_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter bit          ACC_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    input  logic             in_acc,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_z,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_par,
    output logic [WIDTH-1:0] acc_q
);

    logic             s1_v;
    logic             s2_v;
    logic [WIDTH-1:0] z1;
    logic [WIDTH-1:0] z2;
    flags_t           flags_q;
    logic [WIDTH-1:0] acc;

    logic             s1_en;
    logic             s2_en;
    logic             accept;
    logic             use_acc;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] z_c;

    // Backward-propagating enables; each stage advances when downstream can take it.
    assign s2_en    = !s2_v || out_ready;
    assign s1_en    = !s1_v || s2_en;
    assign in_ready = s1_en && !rst;
    assign accept   = in_valid && in_ready;

    // A pending clear forces A to zero so clear-then-op ordering holds within one cycle.
    assign use_acc  = ACC_EN && in_acc;
    assign a_sel    = use_acc ? (acc_clr ? '0 : acc) : in_a;

    gate_vec #(.WIDTH(WIDTH)) u_gate (
        .a  (a_sel),
        .b  (in_b),
        .op (op_t'(in_op)),
        .z  (z_c)
    );

    // Pipeline stages S1 (result) and S2 (result + flags).
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
            z1      <= '0;
            z2      <= '0;
            flags_q <= '0;
        end else begin
            if (s1_en) begin
                s1_v <= accept;
                if (accept) z1 <= z_c;
            end
            if (s2_en) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    z2           <= z1;
                    flags_q.zero <= (z1 == '0);
                    flags_q.ones <= &z1;
                    flags_q.par  <= ^z1;
                end
            end
        end
    end

    // Accumulator written on the same edge that loads S1, so back-to-back in_acc ops see it.
    always_ff @(posedge clk) begin
        if (rst || !ACC_EN) begin
            acc <= '0;
        end else if (accept && use_acc) begin
            acc <= z_c;
        end else if (acc_clr) begin
            acc <= '0;
        end
    end

    assign out_valid = s2_v;
    assign out_z     = z2;
    assign out_zero  = flags_q.zero;
    assign out_ones  = flags_q.ones;
    assign out_par   = flags_q.par;
    assign acc_q     = acc;

endmodule

// File: tb/tb_gate_vec_pipe.sv
// Directed self-checking bench for gate_vec_pipe (WIDTH=8, ACC_EN=1).
module tb_gate_vec_pipe;
    import gate_pkg::*;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    op_t              in_op;
    logic             in_acc;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_z;
    logic             out_zero;
    logic             out_ones;
    logic             out_par;
    logic [WIDTH-1:0] acc_q;

    int n_run  = 0;
    int n_fail = 0;

    logic [7:0] exp_ops [8] = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hC5, 8'h3A};
    logic [7:0] exp_acc [3] = '{8'h01, 8'h03, 8'h07};

    always #5 clk = ~clk;

    gate_vec_pipe #(.WIDTH(WIDTH), .ACC_EN(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_acc    (in_acc),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_zero  (out_zero),
        .out_ones  (out_ones),
        .out_par   (out_par),
        .acc_q     (acc_q)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int recv;

        // Reset held two clocks with a transaction offered.
        rst = 1'b1; in_valid = 1'b1; in_op = OP_AND; in_a = 8'hC5; in_b = 8'h3A;
        in_acc = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_z", 32'(out_z), 32'd0);
        check("rst_flags", 32'({out_zero, out_ones, out_par}), 32'd0);
        check("rst_acc", 32'(acc_q), 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        #1;
        check("post_rst_no_accept", 32'(out_valid), 32'd0);

        // All eight ops back-to-back, two-cycle latency.
        for (int k = 0; k < 10; k++) begin
            in_valid = (k < 8);
            in_op    = op_t'(k[2:0]);
            in_a     = 8'hC5;
            in_b     = 8'h3A;
            #1;
            check("ops_in_ready", 32'(in_ready), 32'd1);
            if (k >= 2) begin
                check("ops_valid", 32'(out_valid), 32'd1);
                check("ops_z", 32'(out_z), 32'(exp_ops[k-2]));
            end
            if (k == 2) check("and_flags", 32'({out_zero, out_ones, out_par}), 32'b100);
            if (k == 3) check("nand_flags", 32'({out_zero, out_ones, out_par}), 32'b010);
            if (k == 8) check("pass_flags", 32'({out_zero, out_ones, out_par}), 32'b000);
            tick();
        end
        #1;
        check("ops_drained", 32'(out_valid), 32'd0);

        // Backpressure: four XOR transactions, consumer stalled for three clocks.
        in_op = OP_XOR;
        sent = 0;
        recv = 0;
        for (int w = 0; w < 30 && recv < 4; w++) begin
            logic acc_now;
            out_ready = (w >= 3);
            in_valid  = (sent < 4);
            in_a      = 8'((sent + 1) << 4);
            in_b      = 8'(sent + 1);
            #1;
            if (w == 2) begin
                check("bp_in_ready_low", 32'(in_ready), 32'd0);
                check("bp_accepts_before_stall", 32'(sent), 32'd2);
                check("bp_stall_valid", 32'(out_valid), 32'd1);
                check("bp_stall_z", 32'(out_z), 32'h11);
            end
            if (w == 3) check("bp_stall_z_stable", 32'(out_z), 32'h11);
            acc_now = in_valid && in_ready;
            if (out_valid && out_ready) begin
                check("bp_z", 32'(out_z), 32'(8'(((recv + 1) << 4) | (recv + 1))));
                recv++;
            end
            if (acc_now) sent++;
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("bp_recv_count", 32'(recv), 32'd4);
        check("bp_sent_count", 32'(sent), 32'd4);
        check("bp_no_dup", 32'(out_valid), 32'd0);

        // Accumulate XOR of 01, 02, 04 after a clear.
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        #1;
        check("acc_cleared", 32'(acc_q), 32'd0);
        for (int k = 0; k < 5; k++) begin
            in_valid = (k < 3);
            in_acc   = 1'b1;
            in_op    = OP_XOR;
            in_a     = 8'hFF;
            in_b     = 8'(1 << k);
            #1;
            if (k >= 2) check("acc_z", 32'(out_z), 32'(exp_acc[k-2]));
            tick();
        end
        in_valid = 1'b0; in_acc = 1'b0;
        #1;
        check("acc_final", 32'(acc_q), 32'h07);

        // Bring acc to 0F, then clear and OR F0 in the same cycle.
        in_valid = 1'b1; in_acc = 1'b1; in_op = OP_OR; in_b = 8'h08;
        tick();
        in_valid = 1'b0; in_acc = 1'b0;
        tick();
        tick();
        #1;
        check("acc_pre_0f", 32'(acc_q), 32'h0F);
        acc_clr = 1'b1; in_acc = 1'b1; in_valid = 1'b1; in_op = OP_OR;
        in_b = 8'hF0; in_a = 8'h5A;
        tick();
        acc_clr = 1'b0; in_valid = 1'b0; in_acc = 1'b0;
        #1;
        check("clr_op_acc", 32'(acc_q), 32'hF0);
        tick();
        #1;
        check("clr_op_valid", 32'(out_valid), 32'd1);
        check("clr_op_z", 32'(out_z), 32'hF0);
        tick();

        // Reset with both stages full and the consumer stalled.
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = OP_AND; in_a = 8'hFF; in_b = 8'hAA;
        tick();
        in_op = OP_OR; in_b = 8'h55;
        tick();
        in_valid = 1'b0;
        #1;
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_z", 32'(out_z), 32'hAA);
        check("full_acc_nonzero", 32'(acc_q != 8'h00), 32'd1);
        rst = 1'b1;
        tick();
        #1;
        check("rst2_out_valid", 32'(out_valid), 32'd0);
        check("rst2_acc", 32'(acc_q), 32'd0);
        check("rst2_out_z", 32'(out_z), 32'd0);
        check("rst2_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0; out_ready = 1'b1;
        #1;
        check("rst2_ready_after", 32'(in_ready), 32'd1);
        tick();
        #1;
        check("rst2_dropped_a", 32'(out_valid), 32'd0);
        tick();
        #1;
        check("rst2_dropped_b", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
